// File: rtl/mmu_req_sched.sv
// Round-robin request scheduler feeding the MMU tree's alloc and free FIFO ports.
// Each path arbitrates its clients into a 2-entry FWFT buffer and tags IDs with the client index.
`ifndef REQ_ID_WIDTH
`define REQ_ID_WIDTH 8
`endif
`ifndef REQ_SIZE_TYPE_WIDTH
`define REQ_SIZE_TYPE_WIDTH 4
`endif
`ifndef ALL_PAGE_IDX_WIDTH
`define ALL_PAGE_IDX_WIDTH 10
`endif
`ifndef FIFO_PTR_WIDTH
`define FIFO_PTR_WIDTH 2
`endif

module mmu_req_path #(
  parameter int N      = 4,
  parameter int CIDX_W = 2,
  parameter int CID_W  = 6,
  parameter int PW     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            vld,
  output logic [N-1:0]            rdy,
  input  logic [N*CID_W-1:0]      cid,
  input  logic [N*PW-1:0]         pld,
  input  logic                    pop,
  output logic [CIDX_W+CID_W-1:0] head_id,
  output logic [PW-1:0]           head_pld,
  output logic [1:0]              cnt
);
  localparam int EW = CIDX_W + CID_W + PW;

  logic [CIDX_W-1:0] rr_q, rr_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [EW-1:0]     mem_q [2];
  logic [EW-1:0]     mem_d [2];

  logic              gnt_found;
  logic [CIDX_W-1:0] gnt_idx, cand;
  logic              push, pop_ok;

  // First valid client at or after the round-robin pointer.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = rr_q + CIDX_W'(k);
      if (!gnt_found && vld[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign push   = gnt_found && (cnt_q != 2'd2) && !rst;
  assign pop_ok = pop && (cnt_q != 2'd0);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rdy
      assign rdy[gi] = push && (gnt_idx == CIDX_W'(gi));
    end
  endgenerate

  always_comb begin
    rr_d     = rr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push) begin
      mem_d[wr_ptr_q] = {gnt_idx, cid[int'(gnt_idx)*CID_W +: CID_W], pld[int'(gnt_idx)*PW +: PW]};
      wr_ptr_d        = ~wr_ptr_q;
      rr_d            = gnt_idx + CIDX_W'(1);
    end
    if (pop_ok) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop_ok})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q     <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < 2; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign {head_id, head_pld} = mem_q[rd_ptr_q];
  assign cnt = cnt_q;
endmodule

module mmu_req_sched #(
  parameter int NUM_CLIENTS = 4,
  parameter int CIDX_W      = 2,
  parameter int ID_W        = `REQ_ID_WIDTH,
  parameter int SIZE_W      = `REQ_SIZE_TYPE_WIDTH,
  parameter int PIDX_W      = `ALL_PAGE_IDX_WIDTH,
  parameter int CNT_W       = `FIFO_PTR_WIDTH + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CLIENTS-1:0]              alloc_cl_vld,
  output logic [NUM_CLIENTS-1:0]              alloc_cl_rdy,
  input  logic [NUM_CLIENTS*(ID_W-CIDX_W)-1:0] alloc_cl_id,
  input  logic [NUM_CLIENTS*SIZE_W-1:0]       alloc_cl_cnt,
  input  logic [NUM_CLIENTS-1:0]              free_cl_vld,
  output logic [NUM_CLIENTS-1:0]              free_cl_rdy,
  input  logic [NUM_CLIENTS*(ID_W-CIDX_W)-1:0] free_cl_id,
  input  logic [NUM_CLIENTS*PIDX_W-1:0]       free_cl_idx,
  input  logic [NUM_CLIENTS*SIZE_W-1:0]       free_cl_cnt,
  input  logic                                alloc_req_pop,
  output logic                                alloc_fifo_empty,
  output logic [ID_W-1:0]                     alloc_req_id,
  output logic [SIZE_W-1:0]                   alloc_req_page_count,
  input  logic                                free_req_pop,
  output logic                                free_fifo_empty,
  output logic [ID_W-1:0]                     free_req_id,
  output logic [PIDX_W-1:0]                   free_req_page_idx,
  output logic [SIZE_W-1:0]                   free_req_page_count,
  output logic [CNT_W-1:0]                    free_fifo_data_count
);
  localparam int FPW = PIDX_W + SIZE_W;

  logic [NUM_CLIENTS*FPW-1:0] free_pld;
  logic [1:0]                 alloc_cnt, free_cnt;

  // Free payload per client is {page index, page count}.
  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_free_pld
      assign free_pld[gi*FPW +: FPW] = {free_cl_idx[gi*PIDX_W +: PIDX_W], free_cl_cnt[gi*SIZE_W +: SIZE_W]};
    end
  endgenerate

  mmu_req_path #(.N(NUM_CLIENTS), .CIDX_W(CIDX_W), .CID_W(ID_W-CIDX_W), .PW(SIZE_W)) u_alloc (
    .clk(clk), .rst(rst), .vld(alloc_cl_vld), .rdy(alloc_cl_rdy),
    .cid(alloc_cl_id), .pld(alloc_cl_cnt), .pop(alloc_req_pop),
    .head_id(alloc_req_id), .head_pld(alloc_req_page_count), .cnt(alloc_cnt)
  );

  mmu_req_path #(.N(NUM_CLIENTS), .CIDX_W(CIDX_W), .CID_W(ID_W-CIDX_W), .PW(FPW)) u_free (
    .clk(clk), .rst(rst), .vld(free_cl_vld), .rdy(free_cl_rdy),
    .cid(free_cl_id), .pld(free_pld), .pop(free_req_pop),
    .head_id(free_req_id), .head_pld({free_req_page_idx, free_req_page_count}), .cnt(free_cnt)
  );

  assign alloc_fifo_empty     = (alloc_cnt == 2'd0);
  assign free_fifo_empty      = (free_cnt == 2'd0);
  assign free_fifo_data_count = CNT_W'(free_cnt);
endmodule

// File: doc/mmu_req_sched.md
Name: mmu_req_sched

Overview:
Multi-client request scheduler placed in front of the MMU tree's alloc and free request interfaces. It round-robin arbitrates NUM_CLIENTS valid/ready requesters per path into a 2-entry first-word-fall-through buffer. Toward the MMU tree it presents the pop/empty FIFO interface the tree already consumes. It tags each request ID with the source client index so downstream response routing can return it to the right client.

Parameters:
NUM_CLIENTS, 4, number of requesters per path (power of 2, 2..8)
CIDX_W, 2, log2(NUM_CLIENTS), client-index tag width
ID_W, `REQ_ID_WIDTH, tagged request ID width
SIZE_W, `REQ_SIZE_TYPE_WIDTH, page-count field width
PIDX_W, `ALL_PAGE_IDX_WIDTH, page-index width
CNT_W, `FIFO_PTR_WIDTH+1, free_fifo_data_count width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_cl_vld  in  NUM_CLIENTS  per-client alloc request valid
alloc_cl_rdy  out  NUM_CLIENTS  per-client alloc accept
alloc_cl_id  in  NUM_CLIENTS*(ID_W-CIDX_W)  packed client IDs, client i at slice i
alloc_cl_cnt  in  NUM_CLIENTS*SIZE_W  packed page counts
free_cl_vld  in  NUM_CLIENTS  per-client free request valid
free_cl_rdy  out  NUM_CLIENTS  per-client free accept
free_cl_id  in  NUM_CLIENTS*(ID_W-CIDX_W)  packed client IDs
free_cl_idx  in  NUM_CLIENTS*PIDX_W  packed page indices
free_cl_cnt  in  NUM_CLIENTS*SIZE_W  packed page counts
alloc_req_pop  in  1  MMU pops alloc head
alloc_fifo_empty  out  1  alloc buffer empty
alloc_req_id  out  ID_W  head ID, {client index, client ID}
alloc_req_page_count  out  SIZE_W  head page count
free_req_pop  in  1  MMU pops free head
free_fifo_empty  out  1  free buffer empty
free_req_id  out  ID_W  head ID, {client index, client ID}
free_req_page_idx  out  PIDX_W  head page index
free_req_page_count  out  SIZE_W  head page count
free_fifo_data_count  out  CNT_W  free buffer occupancy, 0..2 zero-extended

Behaviour:
- Alloc and free paths are identical, fully independent instances of the logic below; there is no cross-path priority.
- Per path, state is: round-robin pointer rr (CIDX_W bits), 2-entry buffer (wr_ptr, rd_ptr, cnt 0..2).
- Grant (combinational):
  - First client with vld set, searching rr, rr+1, ... modulo NUM_CLIENTS.
  - rdy[g] = 1 only for the granted client, and only when cnt<2 and rst=0.
  - All other rdy bits are 0. rdy does not depend on pop (no pop-to-rdy path).
- Accept occurs when vld[g] & rdy[g] at a clock edge:
  - Pushes {g, client ID, fields} into the buffer.
  - rr <= g+1 (wraps modulo NUM_CLIENTS).
  - With no accept, rr holds.
- Output is first-word-fall-through:
  - Head fields are driven from entry rd_ptr; empty = (cnt==0).
  - Latency: accept at edge N -> empty=0 with head valid after edge N (1 cycle).
- Pop:
  - pop while empty is ignored; cnt never underflows.
  - pop with cnt>0 advances rd_ptr (1-bit, wraps 1->0).
  - Push and pop in the same cycle leave cnt unchanged; both pointers advance.
  - Push is never attempted at cnt==2, so there is no overflow.
- free_fifo_data_count = cnt, registered (consistent with free_fifo_empty).
- A request that is held (vld=1, not granted) keeps its fields stable; the client must not retract vld before acceptance.
- Fairness: a continuously requesting client waits at most NUM_CLIENTS-1 accepts.
- Reset (synchronous, active-high):
  - cnt=0, rr=0, pointers=0.
  - empty outputs=1, data_count=0, all rdy=0 while rst=1.
  - Head data outputs are 0 after reset; the buffer storage clears to 0.
- Reset asserted mid-operation discards buffered entries without popping; requests in flight from clients are not accepted during reset.
- Unused ID MSBs: none. The client index occupies the top CIDX_W bits of ID_W.

Test Plan:
- Reset, then client 2 alloc vld, id=0x15, cnt=3 -> alloc_cl_rdy=4'b0100; next cycle alloc_fifo_empty=0, alloc_req_id={2'd2,0x15}, alloc_req_page_count=3.
- All 4 clients hold alloc vld, pop every cycle -> grants in order 0,1,2,3,0; each client is accepted once per 4 accepts.
- Free path, no pops, 3 clients valid -> two accepts, then free_fifo_data_count=2 and all free_cl_rdy=0; one pop -> count 1, next accept proceeds; count never exceeds 2.
- cnt=1 with a simultaneous accept and free_req_pop -> count stays 1 and the head advances to the new entry (idx/cnt match the pushed client).
- Pop asserted while empty -> no change: empty stays 1, count 0, pointers unmoved.
- Fill both buffers, assert rst for 1 cycle with clients valid -> both empty=1, counts 0, rdy=0 during reset; after release, grant restarts from client 0.
